// File: rtl/ats21_cmd_issuer.sv
// -----------------------------------------------------------------------------
// ats21_cmd_issuer
//
// Upstream command front-end for ATS21. Each of two clients (A and B) pushes
// 32-bit instructions into its own FIFO. Whenever either FIFO holds work and
// ATS21 reports ready, one transaction is issued that carries one instruction
// per lane: the high halves on ctrlA/ctrlB with req=1, then the low halves
// with req=0, then one all-zero gap cycle. A lane with nothing queued sends a
// Nop (32'h0000_0000). ATS21 readiness is only sampled between transactions,
// so a transaction that has started always completes.
//
// Parameters:
//   FIFO_DEPTH  entries per client FIFO (power of 2, >= 2)
//   CW          occupancy count width, derived from FIFO_DEPTH
//
// Ports:
//   clk        single clock, all state changes on posedge
//   reset      synchronous, active-high; clears FSM, holding registers, FIFOs
//   a_valid    client A instruction valid
//   a_instr    client A instruction, [31:29] opcode
//   a_ready    client A FIFO can accept (not full)
//   b_valid    client B instruction valid
//   b_instr    client B instruction
//   b_ready    client B FIFO can accept (not full)
//   ats_ready  ATS21 can take a new instruction pair
//   req        ATS21 request strobe, high only during the high-word cycle
//   ctrlA      ATS21 lane A control word
//   ctrlB      ATS21 lane B control word
//   a_count    client A FIFO occupancy
//   b_count    client B FIFO occupancy
//   busy       a transaction is in flight or either FIFO holds work
// -----------------------------------------------------------------------------
module ats21_cmd_issuer #(
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [31:0]   a_instr,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [31:0]   b_instr,
    output logic          b_ready,
    input  logic          ats_ready,
    output logic          req,
    output logic [15:0]   ctrlA,
    output logic [15:0]   ctrlB,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count,
    output logic          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NL = 2;              // lane 0 = client A, lane 1 = client B

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_d;
    logic          launch;
    logic          load;

    logic [31:0]   din      [NL];
    logic [31:0]   head     [NL];
    logic [31:0]   lane_val [NL];
    logic [CW-1:0] count    [NL];
    logic [NL-1:0] ready;
    logic [NL-1:0] nonempty;
    logic [NL-1:0] push;
    logic [NL-1:0] pop;

    logic [31:0]   hold_a;
    logic [31:0]   hold_b;

    assign din[0] = a_instr;
    assign din[1] = b_instr;

    // A full FIFO never accepts, so push and pop can both occur only when
    // the FIFO is neither full nor empty.
    assign push = {b_valid, a_valid} & ready;
    // Every non-empty lane gives up its head on the edge the transaction
    // is launched; an empty lane is padded and pops nothing.
    assign pop  = {NL{load}} & nonempty;

    // -------------------------------------------------------------------------
    // Per-lane FIFO
    // -------------------------------------------------------------------------
    for (genvar l = 0; l < NL; l++) begin : g_lane
        logic [31:0]   mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;

        assign ready[l]    = (count[l] != CW'(FIFO_DEPTH));
        assign nonempty[l] = (count[l] != '0);
        assign head[l]     = mem[rd_ptr];
        assign lane_val[l] = nonempty[l] ? head[l] : 32'h0000_0000;

        // Pointers are PW bits wide, so wrap modulo FIFO_DEPTH comes free
        // from the power-of-two depth.
        always_ff @(posedge clk) begin
            // NOTE: registers use non-blocking assignments so every flop in
            // the design samples the values from before this edge.
            if (reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count[l] <= '0;
            end else begin
                if (push[l]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop[l]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push[l], pop[l]})
                    2'b10:   count[l] <= count[l] + CW'(1);
                    2'b01:   count[l] <= count[l] - CW'(1);
                    default: count[l] <= count[l];
                endcase
            end
        end

        // NOTE: storage is deliberately not reset; count and pointers alone
        // decide which entries are valid, so stale data is never observed.
        always_ff @(posedge clk) begin
            if (push[l] && !reset) begin
                mem[wr_ptr] <= din[l];
            end
        end
    end

    assign a_ready = ready[0];
    assign b_ready = ready[1];
    assign a_count = count[0];
    assign b_count = count[1];

    // -------------------------------------------------------------------------
    // Transaction FSM
    // -------------------------------------------------------------------------
    assign launch = (|nonempty) & ats_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                hold_a <= lane_val[0];
                hold_b <= lane_val[1];
            end
        end
    end

    // Outputs are decoded purely from the state and holding registers, so
    // they change only on a clock edge and never depend on client inputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state;
        load    = 1'b0;
        req     = 1'b0;
        ctrlA   = 16'h0000;
        ctrlB   = 16'h0000;
        case (state)
            // ats_ready is only looked at here, between transactions.
            IDLE, GAP: begin
                if (launch) begin
                    state_d = HI;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HI: begin
                state_d = LO;
                req     = 1'b1;
                ctrlA   = hold_a[31:16];
                ctrlB   = hold_b[31:16];
            end
            LO: begin
                state_d = GAP;
                ctrlA   = hold_a[15:0];
                ctrlB   = hold_b[15:0];
            end
            default: state_d = IDLE;
        endcase
    end

    // GAP drives all-zero control words, which gives ATS21 the opcode-000
    // word it needs after each low half and keeps req from ever being high
    // on two consecutive cycles.
    assign busy = (state != IDLE) | (|nonempty);

endmodule

// File: doc/ats21_cmd_issuer.md
# ats21_cmd_issuer

- Upstream command front-end for ATS21: buffers 32-bit instructions from client A and client B, each in its own FIFO.
- Serializes them onto the ATS21 two-word request protocol: `req` plus `ctrlA`/`ctrlB`, high half then low half.
- Both lanes always issue in the same transaction. An empty lane is padded with a Nop (32'h0000_0000, opcode 000).
- Issue is throttled by ATS21 `ready`, so clients never need to track ATS21 word timing.

## Interface
- `FIFO_DEPTH`, default 4: entries per client FIFO. Must be a power of 2, ≥2.
- `CW`, default $clog2(FIFO_DEPTH)+1: occupancy count width. Derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `a_valid`  in  1  client A instruction valid.
- `a_instr`  in  32  client A instruction; [31:29] opcode.
- `a_ready`  out  1  client A FIFO can accept.
- `b_valid`  in  1  client B instruction valid.
- `b_instr`  in  32  client B instruction.
- `b_ready`  out  1  client B FIFO can accept.
- `ats_ready`  in  1  ATS21 `ready`; high means ATS21 can take a new instruction.
- `req`  out  1  to ATS21 `req`.
- `ctrlA`  out  16  to ATS21 `ctrlA`.
- `ctrlB`  out  16  to ATS21 `ctrlB`.
- `a_count`  out  CW  client A FIFO occupancy.
- `b_count`  out  CW  client B FIFO occupancy.
- `busy`  out  1  high when state ≠ IDLE or either FIFO is non-empty.

## Operation
**FIFOs**
- Push on `x_valid & x_ready`, with `x_ready = (x_count != FIFO_DEPTH)`.
- There is no full-bypass: a push and a pop in the same cycle while full is impossible.
- Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

**Issue condition:** `launch = (a_count != 0 | b_count != 0) & ats_ready`.

**FSM:** IDLE, HI, LO, GAP. Outputs are registered and reflect the current state.
- IDLE: `req`=0, `ctrlA`=`ctrlB`=0. On `launch`: go to HI and latch each lane's FIFO head, or 32'h0 for an empty lane, into a 32-bit holding register.
- Each non-empty lane's FIFO pops on the same edge as its head is latched.
- HI: `req`=1, `ctrlA`=holdA[31:16], `ctrlB`=holdB[31:16]. Always goes to LO next cycle.
- LO: `req`=0, `ctrlA`=holdA[15:0], `ctrlB`=holdB[15:0]. Always goes to GAP next cycle.
- GAP: `req`=0, `ctrl*`=0. The zero opcode field satisfies the ATS21 "bits [15:13]=000 after the low word" rule.
  - On `launch`: go to HI, latching and popping as in IDLE.
  - Otherwise: go to IDLE.
- `ats_ready` is sampled only in IDLE and GAP. Changes of `ats_ready` during HI/LO do not abort or stall the transaction.
- `req` is never high two consecutive cycles, so ATS21 never sees the "second client" two-cycle `req` pattern.
- FIFO order is preserved per lane. Lanes are independent: A entry k pairs with whatever B holds at that launch, not necessarily B entry k.
- Instruction contents pass through unmodified; no opcode checking.

## Timing
- Reset values: `req`=0, `ctrlA`=`ctrlB`=16'h0, `a_count`=`b_count`=0, `a_ready`=`b_ready`=1, `busy`=0, state IDLE.
- Reset mid-transaction:
  - The next cycle shows the reset values.
  - The held instruction and all FIFO contents are discarded.
  - Pushes during reset are ignored.
- Latency: instruction pushed into an empty system at edge E with `ats_ready`=1 gives `req`=1 in the cycle after edge E+1, i.e. the HI state is entered at E+1.
- Back-to-back throughput: one transaction per 3 cycles (HI, LO, GAP). `req` has period 3 while work is pending and `ats_ready`=1.
- `ats_ready` low at the IDLE/GAP sample holds the FSM in IDLE. No pop occurs; FIFOs keep filling until full.

## Test plan
- **Reset:** hold `reset` 4 cycles with `a_valid`=1.
  - Required: `req`=0, `ctrl*`=0, counts 0, `a_ready`=`b_ready`=1, `busy`=0.
  - Required after release: no spurious push occurred during reset.
- **Single A, set_alarm 32'hA000_0045, B empty, `ats_ready`=1:**
  - HI cycle: `req`=1, `ctrlA`=16'hA000, `ctrlB`=16'h0000.
  - LO cycle: `ctrlA`=16'h0045, `ctrlB`=16'h0000.
  - GAP cycle: all zero.
  - Then IDLE; `busy` falls.
- **Both lanes, A=32'h2000_0000, B=32'h2240_0000 pushed same cycle:**
  - One transaction: HI `ctrlA`=16'h2000, `ctrlB`=16'h2240.
  - LO both 16'h0000.
  - Both counts return to 0.
- **Backpressure and full, `ats_ready`=0:**
  - Push 5 A instructions 32'h0000_0001..5: `a_ready` drops after the 4th, `a_count`=4, 5th not accepted.
  - Raise `ats_ready`: four transactions, with `req` high every 3rd cycle, low words 1,2,3,4 in order.
- **`ats_ready` dropped during HI:** the transaction completes (LO, GAP), then the FSM holds IDLE until `ats_ready`=1.
- **Reset asserted during LO:** next cycle `req`=0, `ctrl*`=0, counts 0; the pending FIFO entry is never issued after release.
